router_stage_arbiter: RTL and testbench
=======================================

Name: router_stage_arbiter

Overview:
- Multi-channel router pipeline stage. Buffers flits from NUM_CH input channels in per-channel FIFOs.
- Merges the channels onto one registered valid/ready output using round-robin arbitration with packet locking. A packet is never interleaved with another.
- Sits between the per-port input stages and the crossbar/transmit stage of the packet controller router.

Parameters:
NUM_CH, 4, number of input channels (>=2)
FLIT_WIDTH, 64, flit payload width in bits
FIFO_DEPTH, 4, entries per channel FIFO (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is asynchronous and active-high
in_valid  input  NUM_CH  per-channel flit valid
in_ready  output  NUM_CH  per-channel FIFO can accept
in_flit  input  NUM_CH*FLIT_WIDTH  flits; channel i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH]
in_last  input  NUM_CH  flit is the tail of its packet
out_valid  output  1  output register holds a flit
out_ready  input  1  downstream accepts
out_flit  output  FLIT_WIDTH  registered flit
out_last  output  1  registered tail flag
out_ch  output  $clog2(NUM_CH)  source channel of out_flit
occupancy  output  NUM_CH*($clog2(FIFO_DEPTH)+1)  per-channel FIFO fill count

Behaviour:
- Reset values:
  - out_valid=0, out_flit=0, out_last=0, out_ch=0.
  - All FIFO counts and pointers 0; occupancy=0.
  - Arbiter state IDLE; rr_ptr=0.
  - in_ready=0 while rst is high.
- Reset asserted mid-packet discards all buffered flits and any lock.
- FIFO write:
  - in_ready[i] = !rst && count[i] < FIFO_DEPTH. It is independent of out_ready.
  - No bypass: a full FIFO does not accept a flit even in a cycle where it is popped.
  - A write occurs on a clock edge with in_valid[i] && in_ready[i]. {flit, last} are stored.
  - Push and pop on the same edge leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Output register load:
  - Condition: load = (!out_valid || out_ready) && a channel is granted.
  - On load: the head of the granted FIFO is popped into out_flit/out_last; out_ch = granted channel; out_valid=1.
  - If out_ready is high and nothing is granted, out_valid drops to 0 on that edge.
  - While out_valid && !out_ready, all out_* outputs hold stable.
- Latency: a flit written at edge E0 can appear at the output at E1 at the earliest. Minimum latency is 2 edges from input handshake to out_valid.
- Arbiter FSM:
  - IDLE: grant the first non-empty channel searching rr_ptr, rr_ptr+1, ... modulo NUM_CH.
    - If the loaded flit has last=0, go to LOCKED(ch).
    - If last=1 (single-flit packet), stay IDLE.
    - In both cases rr_ptr = (ch+1) mod NUM_CH.
  - LOCKED(ch): only ch may be granted.
    - If FIFO ch is empty, nothing is granted (bubble). Other channels wait even if non-empty.
    - When a flit with last=1 is loaded, go to IDLE. rr_ptr is unchanged (already ch+1).
- A grant occurs only when load is possible; rr_ptr and state change only on an actual load.
- Wrap-around: rr_ptr = NUM_CH-1 followed by a grant moves rr_ptr to 0.

Test Plan:
- Reset: rst=1 with in_valid=all ones -> in_ready=0, out_valid=0, occupancy=0. Release rst -> in_ready=all ones next cycle.
- Single flit: ch2 writes 0xA5 with last=1 at E0 -> out_valid=1, out_flit=0xA5, out_ch=2, out_last=1 after E1. out_ready=1 -> out_valid=0 after E2.
- Round robin: ch0, ch1 and ch3 each hold one single-flit packet, out_ready=1 -> output order ch0, ch1, ch3, then rr_ptr=0. Refill ch3 and ch0 -> order ch0, ch3.
- Packet lock: ch1 sends a 3-flit packet 0x11, 0x12, 0x13(last) with a 2-cycle gap before the tail, while ch0 is full -> output is 0x11, 0x12, bubble, 0x13. The first ch0 flit appears only after 0x13 is output.
- Full/backpressure: out_ready=0, write FIFO_DEPTH+1 flits on ch0 -> after the first flit moves to the output register, FIFO_DEPTH more fill the FIFO and in_ready[0]=0. out_flit is held stable. Raise out_ready -> flits drain in order and in_ready[0]=1 one cycle after the first pop.
- Mid-packet reset: assert rst after the head flit of a 2-flit packet -> all outputs and state return to reset values. A new single flit on ch3 is then output normally with out_ch=3.

Source files
------------

// File: rtl/router_stage_arbiter.sv
// Router stage that buffers flits per input channel and merges them onto one
// registered valid/ready output, round-robin between packets, never interleaving a packet.
module router_stage_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int FLIT_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_CH-1:0]                           in_valid,
    output logic [NUM_CH-1:0]                           in_ready,
    input  logic [NUM_CH*FLIT_WIDTH-1:0]                in_flit,
    input  logic [NUM_CH-1:0]                           in_last,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [FLIT_WIDTH-1:0]                       out_flit,
    output logic                                        out_last,
    output logic [$clog2(NUM_CH)-1:0]                   out_ch,
    output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]    occupancy
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    logic [FLIT_WIDTH:0]  mem_q    [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]     wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0]     rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]     rd_ptr_d [NUM_CH];
    logic [CNT_W-1:0]     count_q  [NUM_CH];
    logic [CNT_W-1:0]     count_d  [NUM_CH];

    logic [NUM_CH-1:0]    push;
    logic [NUM_CH-1:0]    pop;
    logic [NUM_CH-1:0]    not_empty;
    logic [NUM_CH-1:0]    can_accept;

    state_t               state_q, state_d;
    logic [CH_W-1:0]      lock_ch_q, lock_ch_d;
    logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic                 out_valid_q, out_valid_d;
    logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
    logic                 out_last_q, out_last_d;
    logic [CH_W-1:0]      out_ch_q, out_ch_d;

    logic                 grant_valid;
    logic [CH_W-1:0]      grant_ch;
    logic [CH_W-1:0]      grant_next;
    logic [CH_W-1:0]      cand;
    logic                 load;
    logic [FLIT_WIDTH:0]  head;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_status
            assign can_accept[g] = count_q[g] < CNT_W'(FIFO_DEPTH);
            assign in_ready[g]   = !rst && can_accept[g];
            assign not_empty[g]  = count_q[g] != '0;
            assign push[g]       = in_valid[g] && in_ready[g];
            assign occupancy[g*CNT_W +: CNT_W] = count_q[g];
        end
    endgenerate

    // In IDLE the candidate closest to rr_ptr wins; scanning from the far end lets it overwrite.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        if (state_q == LOCKED) begin
            grant_valid = not_empty[lock_ch_q];
            grant_ch    = lock_ch_q;
        end else begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                cand = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
                if (not_empty[cand]) begin
                    grant_valid = 1'b1;
                    grant_ch    = cand;
                end
            end
        end
    end

    assign load       = (!out_valid_q || out_ready) && grant_valid;
    assign head       = mem_q[grant_ch][rd_ptr_q[grant_ch]];
    assign grant_next = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);

    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        pop         = '0;

        if (load) begin
            pop[grant_ch] = 1'b1;
            out_valid_d   = 1'b1;
            out_flit_d    = head[FLIT_WIDTH-1:0];
            out_last_d    = head[FLIT_WIDTH];
            out_ch_d      = grant_ch;
            case (state_q)
                IDLE: begin
                    rr_ptr_d = grant_next;
                    if (!head[FLIT_WIDTH]) begin
                        state_d   = LOCKED;
                        lock_ch_d = grant_ch;
                    end
                end
                LOCKED: begin
                    if (head[FLIT_WIDTH]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PTR_W'(1) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PTR_W'(1) : rd_ptr_q[i];
            case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_ch_q   <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {in_last[i], in_flit[i*FLIT_WIDTH +: FLIT_WIDTH]};
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_router_stage_arbiter.sv
// Self-checking bench for router_stage_arbiter: a scoreboard of expected output
// flits plus direct checks of reset, latency, backpressure and lock bubbles.
module tb_router_stage_arbiter;

    localparam int NUM_CH     = 4;
    localparam int FLIT_WIDTH = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int CH_W       = $clog2(NUM_CH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic                           clk = 1'b0;
    logic                           rst;
    logic [NUM_CH-1:0]              in_valid;
    logic [NUM_CH-1:0]              in_ready;
    logic [NUM_CH*FLIT_WIDTH-1:0]   in_flit;
    logic [NUM_CH-1:0]              in_last;
    logic                           out_valid;
    logic                           out_ready;
    logic [FLIT_WIDTH-1:0]          out_flit;
    logic                           out_last;
    logic [CH_W-1:0]                out_ch;
    logic [NUM_CH*CNT_W-1:0]        occupancy;

    typedef struct packed {
        logic [CH_W-1:0]       ch;
        logic                  last;
        logic [FLIT_WIDTH-1:0] flit;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    router_stage_arbiter #(
        .NUM_CH    (NUM_CH),
        .FLIT_WIDTH(FLIT_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_flit  (in_flit),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_flit (out_flit),
        .out_last (out_last),
        .out_ch   (out_ch),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // A transfer happens on the next rising edge whenever valid and ready are both seen here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_flit", 64'(sb.size() != 0), 64'd1);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sb_flit", out_flit, mon_e.flit);
                checkOutput("sb_ch", 64'(out_ch), 64'(mon_e.ch));
                checkOutput("sb_last", 64'(out_last), 64'(mon_e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setFlit(input int ch, input logic [63:0] flit, input logic last);
        in_valid[ch]                        = 1'b1;
        in_flit[ch*FLIT_WIDTH +: FLIT_WIDTH] = flit;
        in_last[ch]                         = last;
    endtask

    task automatic applyStimulus();
        tick();
        in_valid = '0;
        in_last  = '0;
    endtask

    task automatic expectFlit(input int ch, input logic [63:0] flit, input logic last);
        exp_t e;
        e.ch   = CH_W'(ch);
        e.last = last;
        e.flit = flit;
        sb.push_back(e);
    endtask

    task automatic doReset();
        rst      = 1'b1;
        in_valid = '0;
        in_last  = '0;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        checkOutput({tag, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '1;
        in_last   = '0;
        in_flit   = '0;
        out_ready = 1'b0;

        // Reset state with every channel trying to write
        tick();
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_out_flit", out_flit, 64'd0);
        checkOutput("rst_out_ch", 64'(out_ch), 64'd0);
        checkOutput("rst_out_last", 64'(out_last), 64'd0);
        in_valid = '0;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'hF);

        // Single flit: two-edge latency, then drains with out_ready
        setFlit(2, 64'hA5, 1'b1);
        expectFlit(2, 64'hA5, 1'b1);
        applyStimulus();
        checkOutput("single_e0_valid", 64'(out_valid), 64'd0);
        checkOutput("single_e0_occ", 64'(occupancy), 64'h040);
        tick();
        checkOutput("single_e1_valid", 64'(out_valid), 64'd1);
        checkOutput("single_e1_flit", out_flit, 64'hA5);
        checkOutput("single_e1_ch", 64'(out_ch), 64'd2);
        checkOutput("single_e1_last", 64'(out_last), 64'd1);
        checkOutput("single_e1_occ", 64'(occupancy), 64'd0);
        out_ready = 1'b1;
        tick();
        checkOutput("single_e2_valid", 64'(out_valid), 64'd0);
        waitDrain("single");

        // Round robin from rr_ptr=0, then wrap back to 0
        doReset();
        out_ready = 1'b0;
        setFlit(0, 64'h30, 1'b1);
        setFlit(1, 64'h31, 1'b1);
        setFlit(3, 64'h33, 1'b1);
        expectFlit(0, 64'h30, 1'b1);
        expectFlit(1, 64'h31, 1'b1);
        expectFlit(3, 64'h33, 1'b1);
        applyStimulus();
        tick();
        out_ready = 1'b1;
        waitDrain("rr1");
        setFlit(3, 64'h3B, 1'b1);
        setFlit(0, 64'h3A, 1'b1);
        expectFlit(0, 64'h3A, 1'b1);
        expectFlit(3, 64'h3B, 1'b1);
        applyStimulus();
        checkOutput("rr2_occ", 64'(occupancy), 64'h201);
        waitDrain("rr2");

        // Packet lock: ch1 packet with a gap before its tail while ch0 is full
        doReset();
        out_ready = 1'b0;
        expectFlit(0, 64'h40, 1'b1);
        expectFlit(1, 64'h11, 1'b0);
        expectFlit(1, 64'h12, 1'b0);
        expectFlit(1, 64'h13, 1'b1);
        for (int k = 1; k <= 4; k++) expectFlit(0, 64'h40 + 64'(k), 1'b1);
        setFlit(0, 64'h40, 1'b1);
        setFlit(1, 64'h11, 1'b0);
        applyStimulus();
        setFlit(0, 64'h41, 1'b1);
        setFlit(1, 64'h12, 1'b0);
        applyStimulus();
        for (int k = 2; k <= 4; k++) begin
            setFlit(0, 64'h40 + 64'(k), 1'b1);
            applyStimulus();
        end
        checkOutput("lock_ch0_full", 64'(in_ready[0]), 64'd0);
        checkOutput("lock_occ", 64'(occupancy), 64'h014);
        checkOutput("lock_hold_flit", out_flit, 64'h40);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("lock_bubble1", 64'(out_valid), 64'd0);
        tick();
        checkOutput("lock_bubble2", 64'(out_valid), 64'd0);
        checkOutput("lock_ch0_waits", 64'(occupancy), 64'h004);
        setFlit(1, 64'h13, 1'b1);
        applyStimulus();
        waitDrain("lock");

        // Full FIFO under backpressure, no bypass on the popping edge
        doReset();
        out_ready = 1'b0;
        for (int k = 0; k <= FIFO_DEPTH; k++) begin
            setFlit(0, 64'h50 + 64'(k), 1'b1);
            expectFlit(0, 64'h50 + 64'(k), 1'b1);
            applyStimulus();
        end
        checkOutput("full_ready_low", 64'(in_ready[0]), 64'd0);
        checkOutput("full_occ", 64'(occupancy), 64'd4);
        checkOutput("full_hold0", out_flit, 64'h50);
        tick();
        tick();
        tick();
        checkOutput("full_hold1", out_flit, 64'h50);
        checkOutput("full_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        setFlit(0, 64'h5F, 1'b1);
        applyStimulus();
        checkOutput("full_ready_back", 64'(in_ready[0]), 64'd1);
        checkOutput("full_no_bypass", 64'(occupancy), 64'd3);
        waitDrain("full");

        // Reset in the middle of a packet drops lock and buffered flits
        doReset();
        out_ready = 1'b0;
        setFlit(1, 64'h61, 1'b0);
        setFlit(2, 64'h62, 1'b1);
        applyStimulus();
        tick();
        checkOutput("mid_head_valid", 64'(out_valid), 64'd1);
        checkOutput("mid_head_ch", 64'(out_ch), 64'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_flit", out_flit, 64'd0);
        checkOutput("mid_rst_ch", 64'(out_ch), 64'd0);
        checkOutput("mid_rst_last", 64'(out_last), 64'd0);
        checkOutput("mid_rst_occ", 64'(occupancy), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        setFlit(3, 64'h63, 1'b1);
        expectFlit(3, 64'h63, 1'b1);
        applyStimulus();
        waitDrain("mid");
        checkOutput("mid_final_occ", 64'(occupancy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
